// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch sequencer.
// Issues one instruction-memory read per instruction over a req/ready
// handshake, holds the fetched word for one execute window, then selects
// the next PC (jump > branch > sequential).
// Optional build macro PC_ALIGN_CHK_EN: misaligned redirect targets are
// rejected (sequential PC is used instead) and addr_err pulses once.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset release, no memory request
// FETCH | imem_req high at imem_addr=pc, waiting for imem_ready
// EXEC  | instr valid for decode; leaves on stall=0 with pc update
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] redirect_pc;
    logic        redirect;

    // Carry out of the adder is discarded, so the PC wraps at 2^32.
    assign pc_plus4  = pc + STEP;
    assign imem_addr = pc;
    assign pc_out    = pc;

    // Redirect selection: jump wins over branch.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = pc_plus4;
        if (jump) begin
            redirect    = 1'b1;
            redirect_pc = jump_target;
        end else if (branch_taken) begin
            redirect    = 1'b1;
            redirect_pc = branch_target;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic addr_err_next;
    logic misaligned;

    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`endif

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = instr;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
`ifdef PC_ALIGN_CHK_EN
        addr_err_next = 1'b0;
`endif
        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_next = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    state_next = FETCH;
`ifdef PC_ALIGN_CHK_EN
                    if (misaligned) begin
                        pc_next       = pc_plus4;
                        addr_err_next = 1'b1;
                    end else begin
                        pc_next = redirect_pc;
                    end
`else
                    pc_next = redirect_pc;
`endif
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // State, PC and instruction registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            instr <= 32'h0000_0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            instr <= instr_next;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    // Error pulse lands in the first FETCH cycle after the rejected redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= addr_err_next;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule
